// File: rtl/arb_mux_n_in_if.sv
// Bundles the source-channel and result-port signals of arb_mux_n_in.
//
// Handshake: a word moves on a channel in the cycle where that channel's
// valid and ready are both high at the rising clock edge. A source holds
// its data and valid until the word is accepted. The result port follows
// the same rule with out_valid/out_ready.
//
// Signals:
//   in_data   N_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid  N_IN        channel i offers a word
//   in_ready  N_IN        channel i word accepted this cycle
//   mode      1           0 = fixed select, 1 = round-robin
//   sel       SEL_W       channel index used in fixed-select mode
//   out_data  WIDTH       registered selected word
//   out_src   SEL_W       channel index out_data came from
//   out_valid 1           out_data/out_src hold a word
//   out_ready 1           consumer takes the word this cycle
// Modports: slave = the mux, master = the producers/consumer side.
interface arb_mux_n_in_if #(
  parameter int WIDTH = 64,
  parameter int N_IN  = 4
);
  localparam int SEL_W = $clog2(N_IN);

  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_ready;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_src;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_src, out_valid
  );

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/arb_mux_n_in.sv
// N-input valid/ready mux with a one-entry registered output stage.
// Picks one source channel per cycle, either by a fixed select index or by
// round-robin arbitration, and holds the accepted word until the consumer
// takes it. A word accepted in cycle t appears on out_data in cycle t+1;
// a drain and a new load may happen in the same cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   bus        arb_mux_n_in_if.slave (channels, mode/sel, result port)
//   dbg_state  output-stage state: 0 = EMPTY, 1 = FULL
//   dbg_rr_ptr current round-robin search start
module arb_mux_n_in #(
  parameter int WIDTH = 64,
  parameter int N_IN  = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             reset_n,
  arb_mux_n_in_if.slave    bus,
  output logic             dbg_state,
  output logic [SEL_W-1:0] dbg_rr_ptr
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_src_q;
  logic [SEL_W-1:0] rr_ptr;

  logic [N_IN-1:0]  grant;
  logic             found;
  logic             can_load;
  logic             xfer;
  logic [SEL_W-1:0] k;
  logic [WIDTH-1:0] k_data;
  logic [SEL_W-1:0] next_ptr;

  // Grant is one-hot or zero. In fixed mode an out-of-range sel simply
  // matches no channel. In round-robin mode the search starts at rr_ptr
  // and wraps; rr_ptr is always < N_IN so one subtraction is enough.
  always_comb begin
    int idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    if (!bus.mode) begin
      for (int i = 0; i < N_IN; i++) begin
        if (int'(bus.sel) == i) grant[i] = bus.in_valid[i];
      end
    end else begin
      for (int off = 0; off < N_IN; off++) begin
        idx = int'(rr_ptr) + off;
        if (idx >= N_IN) idx = idx - N_IN;
        if (!found && bus.in_valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  // out_ready reaches in_ready combinationally so a full stage can drain
  // and reload in one cycle.
  assign can_load     = !out_valid_q || bus.out_ready;
  assign bus.in_ready = reset_n ? (grant & {N_IN{can_load}}) : '0;
  assign xfer         = |(bus.in_valid & bus.in_ready);

  always_comb begin
    k      = '0;
    k_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant[i]) begin
        k      = SEL_W'(i);
        k_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign next_ptr = (int'(k) == N_IN - 1) ? '0 : k + SEL_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (xfer) begin
            state       <= FULL;
            out_valid_q <= 1'b1;
          end
        end
        FULL: begin
          if (!xfer && bus.out_ready) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
      if (xfer) begin
        out_data_q <= k_data;
        out_src_q  <= k;
        if (bus.mode) rr_ptr <= next_ptr;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid_q;
  assign dbg_state     = state;
  assign dbg_rr_ptr    = rr_ptr;

endmodule
